// File: rtl/seq_issue_pkg.sv
// ---------------------------------------------------------------------------
// seq_definitions
//
// Shared definitions for the sequencer issue stage: datapath widths,
// register-file depth, opcode and FSM state encodings, instruction field
// positions and a decode helper that splits an instruction word into its
// fields.
//
// No ports (package).
// ---------------------------------------------------------------------------
package seq_definitions;

   // Datapath / register width, shared with seq_add and seq_mult.
   localparam int alu_width  = 8;
   // Instruction word width.
   localparam int inst_width = 8;
   // Register-file depth; tied to the 2-bit register fields.
   localparam int num_regs   = 4;
   localparam int reg_addr_w = $clog2(num_regs);

   // Instruction field positions.
   localparam int op_msb      = 7;
   localparam int op_lsb      = 6;
   localparam int rs0_msb     = 5;
   localparam int rs0_lsb     = 4;
   localparam int rs1_msb     = 3;
   localparam int rs1_lsb     = 2;
   localparam int rd_msb      = 1;
   localparam int rd_lsb      = 0;
   localparam int push_rd_msb = 5;
   localparam int push_rd_lsb = 4;
   localparam int imm_msb     = 3;
   localparam int imm_lsb     = 0;
   localparam int imm_w       = imm_msb - imm_lsb + 1;

   // Opcodes carried in the top two instruction bits.
   typedef enum logic [1:0] {
      OP_PUSH = 2'b00,
      OP_ADD  = 2'b01,
      OP_MULT = 2'b10,
      OP_SEND = 2'b11
   } op_e;

   // Issue-stage FSM states.
   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_EXEC = 2'b01,
      ST_SEND = 2'b10
   } state_e;

   // Fully decoded instruction. The imm field is already sign-extended
   // to the datapath width so consumers never deal with the raw nibble.
   typedef struct packed {
      op_e                   op;
      logic [reg_addr_w-1:0] rs0;
      logic [reg_addr_w-1:0] rs1;
      logic [reg_addr_w-1:0] rd;
      logic [alu_width-1:0]  imm;
   } decoded_t;

   // PUSH keeps its destination in the field ADD/MULT use for rs0, so the
   // rd selection depends on the opcode. The other fields are extracted
   // unconditionally and simply ignored by ops that do not use them.
   function automatic decoded_t decode(input logic [inst_width-1:0] inst);
      decoded_t d;
      d.op  = op_e'(inst[op_msb:op_lsb]);
      d.rs0 = inst[rs0_msb:rs0_lsb];
      d.rs1 = inst[rs1_msb:rs1_lsb];
      if (d.op == OP_PUSH) begin
         d.rd = inst[push_rd_msb:push_rd_lsb];
      end else begin
         d.rd = inst[rd_msb:rd_lsb];
      end
      d.imm = {{(alu_width - imm_w){inst[imm_msb]}}, inst[imm_msb:imm_lsb]};
      return d;
   endfunction

endpackage

// File: rtl/seq_issue_rf.sv
// ---------------------------------------------------------------------------
// seq_rf
//
// num_regs x alu_width register file for the issue stage. Two combinational
// read ports feed the operand latches; one synchronous write port takes
// PUSH immediates and ALU results. A synchronous reset clears every entry.
//
// Ports:
//   clk          system clock
//   rst          synchronous active-high clear of all entries
//   i_rd_addr_a  read port A address      o_rd_data_a  read port A data
//   i_rd_addr_b  read port B address      o_rd_data_b  read port B data
//   i_wr_en      write enable
//   i_wr_addr    write address
//   i_wr_data    write data
// ---------------------------------------------------------------------------
module seq_rf
   import seq_definitions::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic [reg_addr_w-1:0] i_rd_addr_a,
   input  logic [reg_addr_w-1:0] i_rd_addr_b,
   output logic [alu_width-1:0]  o_rd_data_a,
   output logic [alu_width-1:0]  o_rd_data_b,
   input  logic                  i_wr_en,
   input  logic [reg_addr_w-1:0] i_wr_addr,
   input  logic [alu_width-1:0]  i_wr_data
);

   logic [alu_width-1:0] regs_q [num_regs];

   // Storage update. Reset wins over a coincident write so an instruction
   // caught in flight by reset never lands in the register file.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < num_regs; i++) begin
            regs_q[i] <= '0;
         end
      end else if (i_wr_en) begin
         regs_q[i_wr_addr] <= i_wr_data;
      end
   end

   // Reads are combinational so the issue stage can latch operands in the
   // same cycle it accepts an instruction.
   assign o_rd_data_a = regs_q[i_rd_addr_a];
   assign o_rd_data_b = regs_q[i_rd_addr_b];

endmodule

// File: rtl/seq_issue.sv
// ---------------------------------------------------------------------------
// seq_issue
//
// Instruction issue and register-file stage of the sequencer datapath.
// Accepts one instruction at a time over a valid/ready handshake, reads its
// operands from seq_rf, drives the shared ALU operand bus towards seq_add /
// seq_mult, writes the ALU result (or a PUSH immediate) back, and streams a
// register out over the transmit handshake for SEND.
//
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   i_inst          instruction word
//   i_inst_valid    instruction present
//   o_inst_ready    stage can accept an instruction (IDLE only)
//   o_alu_a/b       operand bus to seq_add / seq_mult
//   o_add_valid     request to seq_add
//   o_mult_valid    request to seq_mult
//   i_add_data/valid   seq_add result
//   i_mult_data/valid  seq_mult result
//   o_tx_data/valid transmit data for SEND
//   i_tx_ready      consumer accepts o_tx_data
// ---------------------------------------------------------------------------
module seq_issue
   import seq_definitions::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic [inst_width-1:0] i_inst,
   input  logic                  i_inst_valid,
   output logic                  o_inst_ready,
   output logic [alu_width-1:0]  o_alu_a,
   output logic [alu_width-1:0]  o_alu_b,
   output logic                  o_add_valid,
   output logic                  o_mult_valid,
   input  logic [alu_width-1:0]  i_add_data,
   input  logic                  i_add_valid,
   input  logic [alu_width-1:0]  i_mult_data,
   input  logic                  i_mult_valid,
   output logic [alu_width-1:0]  o_tx_data,
   output logic                  o_tx_valid,
   input  logic                  i_tx_ready
);

   state_e                state_q, state_d;
   op_e                   op_q, op_d;
   logic [reg_addr_w-1:0] rd_q, rd_d;
   logic [alu_width-1:0]  opa_q, opa_d;
   logic [alu_width-1:0]  opb_q, opb_d;

   decoded_t              dec;
   logic [alu_width-1:0]  rf_a;
   logic [alu_width-1:0]  rf_b;
   logic                  wr_en;
   logic [alu_width-1:0]  wr_data;

   // Decode is purely combinational on the presented word; it is only
   // acted upon when the instruction is actually accepted in IDLE.
   assign dec = decode(i_inst);

   seq_rf u_rf (
      .clk         (clk),
      .rst         (rst),
      .i_rd_addr_a (dec.rs0),
      .i_rd_addr_b (dec.rs1),
      .o_rd_data_a (rf_a),
      .o_rd_data_b (rf_b),
      .i_wr_en     (wr_en),
      .i_wr_addr   (rd_q),
      .i_wr_data   (wr_data)
   );

   // The operand latches sit directly on the ALU bus. They only change on
   // accept, so the operands stay put for however long the ALU stalls.
   assign o_alu_a = opa_q;
   assign o_alu_b = opb_q;

   // State and instruction latches. Reset drops whatever was in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         op_q    <= OP_PUSH;
         rd_q    <= '0;
         opa_q   <= '0;
         opb_q   <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         rd_q    <= rd_d;
         opa_q   <= opa_d;
         opb_q   <= opb_d;
      end
   end

   // Next-state, writeback and handshake outputs.
   // Handshake outputs are masked by rst so they read as idle during the
   // reset cycle itself, whatever state the FSM happens to be in. Only one
   // instruction is ever in flight and its writeback completes before the
   // return to IDLE, so the next instruction always reads fresh registers.
   // A PUSH has no second source register, so its sign-extended immediate
   // rides in the opB latch and is written back from there.
   always_comb begin
      state_d      = state_q;
      op_d         = op_q;
      rd_d         = rd_q;
      opa_d        = opa_q;
      opb_d        = opb_q;
      o_inst_ready = 1'b0;
      o_add_valid  = 1'b0;
      o_mult_valid = 1'b0;
      o_tx_valid   = 1'b0;
      o_tx_data    = '0;
      wr_en        = 1'b0;
      wr_data      = '0;

      case (state_q)
         ST_IDLE: begin
            o_inst_ready = ~rst;
            if (i_inst_valid && !rst) begin
               op_d  = dec.op;
               rd_d  = dec.rd;
               opa_d = rf_a;
               opb_d = (dec.op == OP_PUSH) ? dec.imm : rf_b;
               state_d = (dec.op == OP_SEND) ? ST_SEND : ST_EXEC;
            end
         end

         ST_EXEC: begin
            case (op_q)
               OP_PUSH: begin
                  wr_en   = 1'b1;
                  wr_data = opb_q;
                  state_d = ST_IDLE;
               end
               OP_ADD: begin
                  o_add_valid = ~rst;
                  if (i_add_valid) begin
                     wr_en   = 1'b1;
                     wr_data = i_add_data;
                     state_d = ST_IDLE;
                  end
               end
               OP_MULT: begin
                  o_mult_valid = ~rst;
                  if (i_mult_valid) begin
                     wr_en   = 1'b1;
                     wr_data = i_mult_data;
                     state_d = ST_IDLE;
                  end
               end
               default: begin
                  state_d = ST_IDLE;
               end
            endcase
         end

         ST_SEND: begin
            o_tx_valid = ~rst;
            o_tx_data  = rst ? '0 : opa_q;
            if (i_tx_ready) begin
               state_d = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_seq_issue.sv
// ---------------------------------------------------------------------------
// tb_seq_issue
//
// Self-checking bench for seq_issue. A transaction-level reference model
// (register array plus one "current instruction" record) predicts the
// handshake outputs each cycle; every SEND pushes its expected word into a
// scoreboard queue that an independent monitor pops on each transmit
// handshake. The bench also plays the part of seq_add / seq_mult with a
// configurable response latency.
// ---------------------------------------------------------------------------
module tb_seq_issue;
   import seq_definitions::*;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] i_inst;
   logic       i_inst_valid;
   logic       o_inst_ready;
   logic [7:0] o_alu_a;
   logic [7:0] o_alu_b;
   logic       o_add_valid;
   logic       o_mult_valid;
   logic [7:0] i_add_data;
   logic       i_add_valid;
   logic [7:0] i_mult_data;
   logic       i_mult_valid;
   logic [7:0] o_tx_data;
   logic       o_tx_valid;
   logic       i_tx_ready;

   int checks = 0;
   int errors = 0;

   // Reference model state.
   logic [7:0] mrf [4];
   logic [7:0] txq [$];
   logic [7:0] instQ [$];
   bit         busy = 1'b0;
   op_e        curOp = OP_PUSH;
   logic [7:0] curA = 8'h00;
   logic [7:0] curB = 8'h00;
   int         stallLeft = 0;
   int         aluLeft = 0;
   int         txStallFixed = 0;
   int         aluLatFixed = 0;
   bit         rstReq = 1'b0;
   bit         rstAluPoke = 1'b0;

   // Monitor state.
   logic       prevValid = 1'b0;
   logic [7:0] prevData = 8'h00;
   logic [7:0] monExp;

   always #5 clk = ~clk;

   seq_issue dut (
      .clk          (clk),
      .rst          (rst),
      .i_inst       (i_inst),
      .i_inst_valid (i_inst_valid),
      .o_inst_ready (o_inst_ready),
      .o_alu_a      (o_alu_a),
      .o_alu_b      (o_alu_b),
      .o_add_valid  (o_add_valid),
      .o_mult_valid (o_mult_valid),
      .i_add_data   (i_add_data),
      .i_add_valid  (i_add_valid),
      .i_mult_data  (i_mult_data),
      .i_mult_valid (i_mult_valid),
      .o_tx_data    (o_tx_data),
      .o_tx_valid   (o_tx_valid),
      .i_tx_ready   (i_tx_ready)
   );

   // Single comparison point: counts the check and reports any difference.
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Apply an accepted instruction to the reference model. Results are
   // computed straight from the instruction semantics at accept time;
   // since only one instruction is ever in flight this ordering is exact.
   task automatic modelIssue(input logic [7:0] ins);
      op_e        op;
      logic [1:0] rs0;
      logic [1:0] rs1;
      logic [1:0] rd;
      op  = op_e'(ins[7:6]);
      rs0 = ins[5:4];
      rs1 = ins[3:2];
      rd  = ins[1:0];
      busy  = 1'b1;
      curOp = op;
      curA  = mrf[rs0];
      curB  = mrf[rs1];
      stallLeft = (txStallFixed >= 0) ? txStallFixed : int'($urandom_range(0, 4));
      aluLeft   = (aluLatFixed >= 0) ? aluLatFixed : int'($urandom_range(0, 3));
      case (op)
         OP_PUSH: mrf[rs0] = {{4{ins[3]}}, ins[3:0]};
         OP_ADD:  mrf[rd]  = curA + curB;
         OP_MULT: mrf[rd]  = curA * curB;
         default: txq.push_back(curA);
      endcase
   endtask

   // One clock of stimulus, called just after a falling edge: drive every
   // input, then compare the handshake outputs against the model and
   // advance the model to what the next rising edge will do.
   task automatic driveCycle();
      bit done;
      if (rstReq) begin
         rst          = 1'b1;
         i_inst_valid = 1'b0;
         i_tx_ready   = 1'b0;
         i_add_valid  = 1'b0;
         i_mult_valid = rstAluPoke;
         i_mult_data  = 8'h5A;
         #1;
         checkOutput("rst_inst_ready", o_inst_ready, 0);
         checkOutput("rst_add_valid", o_add_valid, 0);
         checkOutput("rst_mult_valid", o_mult_valid, 0);
         checkOutput("rst_tx_valid", o_tx_valid, 0);
         checkOutput("rst_tx_data", o_tx_data, 0);
         if (busy && curOp == OP_SEND) void'(txq.pop_back());
         busy = 1'b0;
         for (int r = 0; r < 4; r++) mrf[r] = 8'h00;
         rstReq = 1'b0;
         rstAluPoke = 1'b0;
         return;
      end

      rst          = 1'b0;
      i_inst_valid = (instQ.size() > 0);
      i_inst       = (instQ.size() > 0) ? instQ[0] : 8'($urandom);

      if (busy && curOp == OP_SEND) begin
         if (stallLeft > 0) begin
            i_tx_ready = 1'b0;
            stallLeft--;
         end else begin
            i_tx_ready = 1'b1;
         end
      end else begin
         i_tx_ready = 1'($urandom_range(0, 1));
      end

      // Stand-in for seq_add / seq_mult: answer from the operand bus after
      // the chosen latency.
      i_add_valid  = 1'b0;
      i_mult_valid = 1'b0;
      i_add_data   = 8'($urandom);
      i_mult_data  = 8'($urandom);
      if (busy && (curOp == OP_ADD || curOp == OP_MULT)) begin
         if (aluLeft > 0) begin
            aluLeft--;
         end else if (curOp == OP_ADD) begin
            i_add_valid = 1'b1;
            i_add_data  = o_alu_a + o_alu_b;
         end else begin
            i_mult_valid = 1'b1;
            i_mult_data  = o_alu_a * o_alu_b;
         end
      end

      #1;
      checkOutput("inst_ready", o_inst_ready, !busy);
      checkOutput("add_valid", o_add_valid, busy && curOp == OP_ADD);
      checkOutput("mult_valid", o_mult_valid, busy && curOp == OP_MULT);
      checkOutput("tx_valid", o_tx_valid, busy && curOp == OP_SEND);
      if (busy && (curOp == OP_ADD || curOp == OP_MULT)) begin
         checkOutput("alu_a", o_alu_a, curA);
         checkOutput("alu_b", o_alu_b, curB);
      end

      if (busy) begin
         done = 1'b0;
         case (curOp)
            OP_PUSH: done = 1'b1;
            OP_ADD:  done = i_add_valid;
            OP_MULT: done = i_mult_valid;
            default: done = i_tx_ready;
         endcase
         if (done) busy = 1'b0;
      end else if (i_inst_valid) begin
         modelIssue(instQ.pop_front());
      end
   endtask

   task automatic applyStimulus(input int cycles);
      for (int c = 0; c < cycles; c++) begin
         @(negedge clk);
         driveCycle();
      end
   endtask

   // Run until every queued instruction has issued and completed, bounded.
   task automatic drain(input int maxCycles);
      int n;
      n = 0;
      while ((instQ.size() > 0 || busy) && n < maxCycles) begin
         @(negedge clk);
         driveCycle();
         n++;
      end
      if (instQ.size() > 0 || busy) begin
         checks++;
         errors++;
         $display("[TB] FAIL drain_timeout: got %0d queued, busy %0d, expected 0 and 0", instQ.size(), busy);
      end
   endtask

   // Transmit monitor: pops the scoreboard on every handshake and checks
   // that a stalled word stays valid and unchanged.
   always @(negedge clk) begin
      #2;
      if (rst) begin
         prevValid = 1'b0;
      end else begin
         if (prevValid) begin
            checkOutput("tx_hold_valid", o_tx_valid, 1);
            checkOutput("tx_hold_data", o_tx_data, prevData);
         end
         if (o_tx_valid && i_tx_ready) begin
            if (txq.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL tx_unexpected: got 0x%0h with no word expected", o_tx_data);
            end else begin
               monExp = txq.pop_front();
               checkOutput("tx_data", o_tx_data, monExp);
            end
            prevValid = 1'b0;
         end else begin
            prevValid = o_tx_valid;
            prevData  = o_tx_data;
         end
      end
   end

   initial begin
      rst          = 1'b1;
      i_inst       = 8'h00;
      i_inst_valid = 1'b0;
      i_add_data   = 8'h00;
      i_add_valid  = 1'b0;
      i_mult_data  = 8'h00;
      i_mult_valid = 1'b0;
      i_tx_ready   = 1'b0;
      for (int r = 0; r < 4; r++) mrf[r] = 8'h00;

      repeat (3) @(negedge clk);
      #1;
      checkOutput("reset_inst_ready", o_inst_ready, 0);
      checkOutput("reset_add_valid", o_add_valid, 0);
      checkOutput("reset_mult_valid", o_mult_valid, 0);
      checkOutput("reset_tx_valid", o_tx_valid, 0);
      checkOutput("reset_tx_data", o_tx_data, 0);
      checkOutput("reset_alu_a", o_alu_a, 0);
      checkOutput("reset_alu_b", o_alu_b, 0);

      // Basic add, sign extension, wrap, multiply truncation.
      txStallFixed = 0;
      aluLatFixed  = 0;
      instQ = '{8'h03, 8'h15, 8'h46, 8'hE0,
                8'h0F, 8'hC0, 8'h40, 8'hC0,
                8'h14, 8'h95, 8'hD0, 8'h95, 8'hD0};
      drain(200);

      // Stalled SEND with a PUSH held behind it.
      txStallFixed = 5;
      instQ = '{8'hE0, 8'h21, 8'hD0};
      drain(100);

      // Reset in the middle of a stalled SEND.
      txStallFixed = 20;
      instQ = '{8'hC0};
      applyStimulus(3);
      rstReq = 1'b1;
      applyStimulus(1);

      // Reset in the middle of a stalled MULT, with a result arriving in
      // the reset cycle that must not be written.
      txStallFixed = 0;
      aluLatFixed  = 20;
      instQ = '{8'h37, 8'hBF};
      applyStimulus(5);
      rstReq = 1'b1;
      rstAluPoke = 1'b1;
      applyStimulus(1);

      // Every register reads back as cleared.
      aluLatFixed = 0;
      instQ = '{8'hC0, 8'hD0, 8'hE0, 8'hF0};
      drain(100);

      // Randomized back-to-back traffic with random ALU and consumer stalls.
      txStallFixed = -1;
      aluLatFixed  = -1;
      for (int k = 0; k < 300; k++) instQ.push_back(8'($urandom_range(0, 255)));
      drain(8000);

      applyStimulus(3);
      checkOutput("txq_drained", txq.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/seq_issue.md
Name: seq_issue

Overview:
Instruction issue and register-file stage of the sequencer datapath, sitting directly upstream of seq_add and seq_mult.
- Accepts 8-bit instructions over a valid/ready handshake and decodes them.
- Reads operands from a 4-entry register file, drives the shared ALU operand bus, and writes ALU results back.
- Streams register contents out through a transmit handshake for the send op.

Parameters:
alu_width, 8, datapath and register width; same value as the seq_add/seq_mult instances.
num_regs, 4, register-file depth; fixed by the 2-bit register fields.
inst_width, 8, instruction width.

Ports:
clk  input  1  system clock.
rst  input  1  synchronous, active-high reset.
i_inst  input  inst_width  instruction word.
i_inst_valid  input  1  instruction present.
o_inst_ready  output  1  stage can accept an instruction.
o_alu_a  output  alu_width  operand A to seq_add/seq_mult i_data_a.
o_alu_b  output  alu_width  operand B to seq_add/seq_mult i_data_b.
o_add_valid  output  1  to seq_add i_valid.
o_mult_valid  output  1  to seq_mult i_valid.
i_add_data  input  alu_width  seq_add o_data.
i_add_valid  input  1  seq_add o_valid.
i_mult_data  input  alu_width  seq_mult o_data.
i_mult_valid  input  1  seq_mult o_valid.
o_tx_data  output  alu_width  register value for the send op.
o_tx_valid  output  1  o_tx_data valid.
i_tx_ready  input  1  consumer accepts o_tx_data.

Behaviour:
- All state updates on posedge clk. rst is synchronous, active-high and overrides everything.
- Reset values:
  - all registers = 0, state = IDLE.
  - o_alu_a = o_alu_b = 0.
  - o_add_valid = o_mult_valid = o_tx_valid = 0, o_tx_data = 0.
  - o_inst_ready = 0 while rst is high; it becomes 1 in the first cycle after rst deasserts.
- Instruction encoding, op = i_inst[7:6]:
  - 00 PUSH: rd = [5:4], imm = [3:0], sign-extended to alu_width.
  - 01 ADD and 10 MULT: rs0 = [5:4], rs1 = [3:2], rd = [1:0].
  - 11 SEND: rs0 = [5:4]; [3:0] ignored.
- FSM states:
  - IDLE: o_inst_ready = 1. On i_inst_valid & o_inst_ready in cycle N: latch op and rd; latch rf[rs0] into opA and rf[rs1] into opB.
    - PUSH, ADD or MULT goes to EXEC.
    - SEND goes to SEND.
  - EXEC (cycle N+1 onward): o_inst_ready = 0, o_alu_a = opA, o_alu_b = opB.
    - ADD: o_add_valid = 1. At the clock edge with i_add_valid = 1, rf[rd] <= i_add_data, then go to IDLE.
    - MULT: same, using o_mult_valid, i_mult_valid and i_mult_data.
    - If the ALU valid is low, stay in EXEC and hold the operands.
    - PUSH: rf[rd] <= sext(imm) at the end of N+1, then go to IDLE.
  - SEND: o_tx_valid = 1, o_tx_data = opA, both held stable until i_tx_ready. At the clock edge with o_tx_valid & i_tx_ready, go to IDLE.
- Latency and throughput:
  - Nominal latency is 2 cycles per instruction; the written register is visible to an instruction accepted in cycle N+2.
  - Because all writeback finishes before IDLE, no read-after-write hazard exists.
- Arithmetic: results are accepted as presented, modulo 2^alu_width. No overflow flag.
- o_add_valid and o_mult_valid are never high simultaneously, and never high outside EXEC.
- o_tx_valid is high only in SEND.
- rd = rs0 or rd = rs1 is legal: the old value is read, the new value is written.
- i_inst_valid while not ready is ignored. The instruction is not consumed, and the upstream holds it.
- Reset mid-operation: the in-flight instruction is dropped with no writeback; o_tx_valid falls in the reset cycle.
- A SEND with i_tx_ready tied high completes in 1 cycle in SEND.

Decomposition:
- Shared package seq_definitions: alu_width, inst_width, num_regs, op encodings (OP_PUSH/ADD/MULT/SEND), state encodings, instruction field positions.
- One natural sub-module: seq_rf, the 4×alu_width register file with 2 combinational read ports, 1 synchronous write port, and synchronous clear.
- FSM and decode stay in seq_issue.

Test Plan:
- PUSH r0,3; PUSH r1,5; ADD r0,r1→r2; SEND r2 with i_tx_ready=1 -> o_tx_data=0x08 with o_tx_valid for 1 cycle; o_add_valid high exactly 1 cycle per ADD.
- PUSH r0,-1 (imm 4'hF); SEND r0 -> 0xFF (sign extension). Then ADD r0,r0→r0; SEND -> 0xFE (wrap).
- PUSH r1,4; MULT r1,r1→r1 twice -> 0x10, then 0x00 (truncation at width 8); o_mult_valid only during MULT EXEC.
- SEND with i_tx_ready low for 5 cycles -> o_tx_valid and o_tx_data stable throughout, o_inst_ready=0; a held i_inst_valid is not consumed until the cycle after the handshake.
- Assert rst during SEND and during MULT EXEC -> next cycle o_tx_valid=0, all valids 0, no writeback; SEND r0..r3 after reset -> all 0x00.
- Continuous i_inst_valid with back-to-back instructions -> exactly one accept every 2 cycles (every 2+k cycles for stalled SEND), instruction order preserved.
